// File: rtl/vram_arbiter_pkg.sv
// Shared types and constants for the VRAM arbiter.
//   arb_state_t : command tracking state (idle / issued / busy)
//   owner_t     : which source owns the operation in flight
//   DEBT_*      : refresh debt counter width and thresholds
package vram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUED,
        ST_BUSY
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_VIDEO,
        OWN_CPU,
        OWN_REFRESH
    } owner_t;

    localparam int unsigned DEBT_W = 2;
    localparam logic [DEBT_W-1:0] DEBT_MAX    = '1;
    localparam logic [DEBT_W-1:0] DEBT_URGENT = 2'd2;

endpackage

// File: rtl/vram_arbiter_refresh_scheduler.sv
// Refresh obligation tracker for the VRAM arbiter.
//   clk, resetn      : clock, asynchronous active-low reset
//   refresh_grant    : arbiter is issuing a refresh this cycle
//   refresh_urgent   : debt >= 2, refresh must win arbitration
//   refresh_lazy     : debt >= 1, refresh may use idle slots
//   refresh_overrun  : sticky, a new obligation arrived with debt saturated
module refresh_scheduler
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 810
) (
    input  logic clk,
    input  logic resetn,
    input  logic refresh_grant,
    output logic refresh_urgent,
    output logic refresh_lazy,
    output logic refresh_overrun
);

    localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);

    logic [CNT_W-1:0]  interval_q;
    logic [DEBT_W-1:0] debt_q;
    logic              tick;

    assign tick = (interval_q == CNT_W'(REFRESH_CYCLES - 1));

    // A new obligation and a refresh grant in the same cycle cancel out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            interval_q      <= '0;
            debt_q          <= '0;
            refresh_overrun <= 1'b0;
        end else begin
            interval_q <= tick ? '0 : interval_q + CNT_W'(1);
            if (tick && !refresh_grant) begin
                if (debt_q == DEBT_MAX) begin
                    refresh_overrun <= 1'b1;
                end else begin
                    debt_q <= debt_q + DEBT_W'(1);
                end
            end else if (!tick && refresh_grant && debt_q != '0) begin
                debt_q <= debt_q - DEBT_W'(1);
            end
        end
    end

    assign refresh_urgent = (debt_q >= DEBT_URGENT);
    assign refresh_lazy   = (debt_q != '0);

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the SDRAM controller between video fetch, CPU and refresh.
//   clk, resetn                 : clock, asynchronous active-low reset
//   video_req/addr/ack          : video read request, one-cycle accept pulse
//   video_rdata/rvalid          : video read return
//   cpu_req/we/addr/wdata/wdm   : CPU request, held until cpu_ack
//   cpu_rdata/rvalid            : CPU read return
//   mem_read/write/refresh      : one-cycle commands, issued only when idle
//   mem_addr/din/wdm            : command payload, held between commands
//   mem_dout, mem_busy          : controller read data and busy status
//   refresh_overrun             : sticky refresh debt overflow
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned FREQ           = 54_000_000,
    parameter int unsigned REFRESH_CYCLES = 810,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        video_req,
    input  logic [21:0] video_addr,
    output logic        video_ack,
    output logic [15:0] video_rdata,
    output logic        video_rvalid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [21:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic [1:0]  cpu_wdm,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_refresh,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_wdm,
    input  logic [15:0] mem_dout,
    input  logic        mem_busy,
    output logic        refresh_overrun
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    if (FREQ == 0 || REFRESH_CYCLES < 2 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("vram_arbiter: invalid parameter set");
    end

    arb_state_t    state_q, state_d;
    owner_t        owner_q, owner_d;
    logic          is_read_q, is_read_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          video_ack_d, cpu_ack_d, video_rvalid_d, cpu_rvalid_d;
    logic          mem_read_d, mem_write_d, mem_refresh_d;
    logic [21:0]   mem_addr_d;
    logic [15:0]   mem_din_d, video_rdata_d, cpu_rdata_d;
    logic [1:0]    mem_wdm_d;

    logic          grant_refresh, refresh_urgent, refresh_lazy;

    refresh_scheduler #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh (
        .clk             (clk),
        .resetn          (resetn),
        .refresh_grant   (grant_refresh),
        .refresh_urgent  (refresh_urgent),
        .refresh_lazy    (refresh_lazy),
        .refresh_overrun (refresh_overrun)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_VIDEO;
            is_read_q    <= 1'b0;
            starve_q     <= '0;
            video_ack    <= 1'b0;
            cpu_ack      <= 1'b0;
            video_rvalid <= 1'b0;
            cpu_rvalid   <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_refresh  <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            mem_wdm      <= '0;
            video_rdata  <= '0;
            cpu_rdata    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            is_read_q    <= is_read_d;
            starve_q     <= starve_d;
            video_ack    <= video_ack_d;
            cpu_ack      <= cpu_ack_d;
            video_rvalid <= video_rvalid_d;
            cpu_rvalid   <= cpu_rvalid_d;
            mem_read     <= mem_read_d;
            mem_write    <= mem_write_d;
            mem_refresh  <= mem_refresh_d;
            mem_addr     <= mem_addr_d;
            mem_din      <= mem_din_d;
            mem_wdm      <= mem_wdm_d;
            video_rdata  <= video_rdata_d;
            cpu_rdata    <= cpu_rdata_d;
        end
    end

    // All outputs are registered: this block computes their next values.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        is_read_d      = is_read_q;
        starve_d       = cpu_req ? starve_q : '0;
        video_ack_d    = 1'b0;
        cpu_ack_d      = 1'b0;
        video_rvalid_d = 1'b0;
        cpu_rvalid_d   = 1'b0;
        mem_read_d     = 1'b0;
        mem_write_d    = 1'b0;
        mem_refresh_d  = 1'b0;
        mem_addr_d     = mem_addr;
        mem_din_d      = mem_din;
        mem_wdm_d      = mem_wdm;
        video_rdata_d  = video_rdata;
        cpu_rdata_d    = cpu_rdata;
        grant_refresh  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!mem_busy) begin
                    if (refresh_urgent) begin
                        grant_refresh = 1'b1;
                    end else if (cpu_req && starve_q == SW'(STARVE_LIMIT)) begin
                        cpu_ack_d = 1'b1;
                    end else if (video_req) begin
                        video_ack_d = 1'b1;
                    end else if (cpu_req) begin
                        cpu_ack_d = 1'b1;
                    end else if (refresh_lazy) begin
                        grant_refresh = 1'b1;
                    end

                    if (grant_refresh) begin
                        owner_d       = OWN_REFRESH;
                        is_read_d     = 1'b0;
                        mem_refresh_d = 1'b1;
                        state_d       = ST_ISSUED;
                    end else if (video_ack_d) begin
                        owner_d    = OWN_VIDEO;
                        is_read_d  = 1'b1;
                        mem_read_d = 1'b1;
                        mem_addr_d = video_addr;
                        state_d    = ST_ISSUED;
                        if (cpu_req && starve_q != SW'(STARVE_LIMIT)) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else if (cpu_ack_d) begin
                        owner_d     = OWN_CPU;
                        is_read_d   = !cpu_we;
                        mem_read_d  = !cpu_we;
                        mem_write_d = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_din_d   = cpu_wdata;
                        mem_wdm_d   = cpu_wdm;
                        starve_d    = '0;
                        state_d     = ST_ISSUED;
                    end
                end
            end
            // A controller that never raises busy leaves us parked here.
            ST_ISSUED: begin
                if (mem_busy) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!mem_busy) begin
                    state_d = ST_IDLE;
                    if (is_read_q && owner_q == OWN_VIDEO) begin
                        video_rdata_d  = mem_dout;
                        video_rvalid_d = 1'b1;
                    end
                    if (is_read_q && owner_q == OWN_CPU) begin
                        cpu_rdata_d  = mem_dout;
                        cpu_rvalid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam int unsigned RC = 810;
    localparam int unsigned SL = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        video_req = 1'b0;
    logic [21:0] video_addr = '0;
    logic        video_ack;
    logic [15:0] video_rdata;
    logic        video_rvalid;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [21:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [1:0]  cpu_wdm = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        mem_read, mem_write, mem_refresh;
    logic [21:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_wdm;
    logic [15:0] mem_dout;
    logic        mem_busy;
    logic        refresh_overrun;

    always #5 clk = ~clk;

    vram_arbiter #(
        .FREQ           (54_000_000),
        .REFRESH_CYCLES (RC),
        .STARVE_LIMIT   (SL)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .video_req       (video_req),
        .video_addr      (video_addr),
        .video_ack       (video_ack),
        .video_rdata     (video_rdata),
        .video_rvalid    (video_rvalid),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_wdm         (cpu_wdm),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
        .cpu_rvalid      (cpu_rvalid),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_refresh     (mem_refresh),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_wdm         (mem_wdm),
        .mem_dout        (mem_dout),
        .mem_busy        (mem_busy),
        .refresh_overrun (refresh_overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory controller stand-in ----------------
    logic        mc_auto = 1'b0, mc_force = 1'b0, mc_busy = 1'b0, mc_rd = 1'b0;
    logic        man_busy = 1'b1;
    logic [15:0] mc_dout = '0, man_dout = '0;
    int          mc_start = 0, mc_cnt = 0;

    assign mem_busy = mc_auto ? (mc_force | mc_busy) : man_busy;
    assign mem_dout = mc_auto ? mc_dout : man_dout;

    always @(negedge clk) begin
        if (mc_cnt > 0) begin
            mc_cnt--;
            if (mc_cnt == 0) begin
                mc_busy = 1'b0;
                if (mc_rd) mc_dout = 16'($urandom);
            end
        end else if (mc_start > 0) begin
            mc_start--;
            if (mc_start == 0) begin
                mc_busy = 1'b1;
                mc_cnt  = $urandom_range(5, 1);
            end
        end else if (mc_auto && (mem_read || mem_write || mem_refresh)) begin
            mc_rd    = mem_read;
            mc_start = $urandom_range(2, 1);
        end
    end

    // ---------------- behavioural reference model ----------------
    // Transaction view: one operation may be in flight; it ends when the
    // controller has been seen busy and then seen idle again.
    int          edge_n = 0, debt = 0, starve = 0, op_own = 0;
    bit          op_live = 0, op_seen = 0, op_rd = 0, m_in_reset = 1;
    logic        e_vack = 0, e_cack = 0, e_rd = 0, e_wr = 0, e_rf = 0;
    logic        e_vrv = 0, e_crv = 0, e_ovr = 0;
    logic [21:0] e_addr = '0;
    logic [15:0] e_din = '0, e_vrd = '0, e_crd = '0;
    logic [1:0]  e_wdm = '0;

    always @(posedge clk) begin
        int who;
        int tick;
        int gref;
        if (!resetn) begin
            edge_n = 0; debt = 0; starve = 0; op_live = 0; op_seen = 0; op_rd = 0;
            m_in_reset = 1;
            e_vack = 0; e_cack = 0; e_rd = 0; e_wr = 0; e_rf = 0;
            e_vrv = 0; e_crv = 0; e_ovr = 0;
            e_addr = '0; e_din = '0; e_wdm = '0; e_vrd = '0; e_crd = '0;
        end else begin
            m_in_reset = 0;
            e_vack = 0; e_cack = 0; e_rd = 0; e_wr = 0; e_rf = 0; e_vrv = 0; e_crv = 0;
            edge_n++;
            tick = (edge_n % RC == 0) ? 1 : 0;
            gref = 0;
            who  = 0;
            if (!op_live) begin
                if (!mem_busy) begin
                    if (debt >= 2)                      who = 3;
                    else if (cpu_req && starve == SL)   who = 2;
                    else if (video_req)                 who = 1;
                    else if (cpu_req)                   who = 2;
                    else if (debt >= 1)                 who = 3;
                end
                if (who != 0) begin
                    op_live = 1; op_seen = 0; op_own = who;
                end
                if (who == 1) begin
                    e_vack = 1; e_rd = 1; e_addr = video_addr; op_rd = 1;
                end else if (who == 2) begin
                    e_cack = 1; e_addr = cpu_addr; op_rd = !cpu_we;
                    if (cpu_we) begin
                        e_wr = 1; e_din = cpu_wdata; e_wdm = cpu_wdm;
                    end else begin
                        e_rd = 1;
                    end
                end else if (who == 3) begin
                    e_rf = 1; gref = 1; op_rd = 0;
                end
            end else if (!op_seen) begin
                if (mem_busy) op_seen = 1;
            end else if (!mem_busy) begin
                op_live = 0;
                if (op_rd && op_own == 1) begin e_vrv = 1; e_vrd = mem_dout; end
                if (op_rd && op_own == 2) begin e_crv = 1; e_crd = mem_dout; end
            end

            debt = debt + tick - gref;
            if (debt > 3) begin
                debt  = 3;
                e_ovr = 1;
            end

            if (!cpu_req || who == 2) starve = 0;
            else if (who == 1 && starve < SL) starve++;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        check("video_ack",       video_ack,       e_vack);
        check("cpu_ack",         cpu_ack,         e_cack);
        check("mem_read",        mem_read,        e_rd);
        check("mem_write",       mem_write,       e_wr);
        check("mem_refresh",     mem_refresh,     e_rf);
        check("video_rvalid",    video_rvalid,    e_vrv);
        check("cpu_rvalid",      cpu_rvalid,      e_crv);
        check("video_rdata",     video_rdata,     e_vrd);
        check("cpu_rdata",       cpu_rdata,       e_crd);
        check("refresh_overrun", refresh_overrun, e_ovr);
        if (e_rd || e_wr || m_in_reset) check("mem_addr", mem_addr, e_addr);
        if (e_wr || m_in_reset) begin
            check("mem_din", mem_din, e_din);
            check("mem_wdm", mem_wdm, e_wdm);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // mode 1: both requesters always asking; mode 2: random requests
    task automatic update_reqs(input int mode);
        if (video_ack) begin
            if (mode == 1 || $urandom_range(1, 0) == 1) begin
                video_req  = 1'b1;
                video_addr = 22'($urandom);
            end else begin
                video_req = 1'b0;
            end
        end else if (!video_req && (mode == 1 || $urandom_range(2, 0) == 0)) begin
            video_req  = 1'b1;
            video_addr = 22'($urandom);
        end
        if (cpu_ack) begin
            if (mode == 1 || $urandom_range(1, 0) == 1) begin
                cpu_req = 1'b1;
                new_cpu();
            end else begin
                cpu_req = 1'b0;
            end
        end else if (!cpu_req && (mode == 1 || $urandom_range(3, 0) == 0)) begin
            cpu_req = 1'b1;
            new_cpu();
        end
    endtask

    task automatic new_cpu();
        cpu_we    = 1'($urandom);
        cpu_addr  = 22'($urandom);
        cpu_wdata = 16'($urandom);
        cpu_wdm   = 2'($urandom);
    endtask

    task automatic traffic(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            update_reqs(mode);
        end
    endtask

    initial begin
        int  cnt;
        int  ngr;
        byte gseq [10];
        bit  seen;

        // Reset with the controller still initialising and video waiting.
        resetn     = 1'b0;
        man_busy   = 1'b1;
        video_req  = 1'b1;
        video_addr = 22'h000ABC;
        repeat (3) step();
        check("rst_video_ack", video_ack, 0);
        check("rst_mem_read",  mem_read,  0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_overrun",   refresh_overrun, 0);
        resetn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (video_ack) cnt++;
        end
        check("no_ack_during_init", cnt, 0);
        man_busy = 1'b0;
        step();
        check("init_video_ack",  video_ack, 1);
        check("init_mem_read",   mem_read,  1);
        check("init_mem_addr",   mem_addr,  22'h000ABC);

        // Video read: busy for four cycles, data 0x5A5A.
        video_req = 1'b0;
        man_busy  = 1'b1;
        repeat (4) step();
        check("vrd_not_early", video_rvalid, 0);
        man_busy = 1'b0;
        man_dout = 16'h5A5A;
        step();
        check("vrd_rvalid", video_rvalid, 1);
        check("vrd_rdata",  video_rdata,  16'h5A5A);
        step();
        check("vrd_rvalid_once", video_rvalid, 0);
        check("vrd_rdata_hold",  video_rdata,  16'h5A5A);

        // CPU write.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 22'h000123;
        cpu_wdata = 16'hBEEF;
        cpu_wdm   = 2'b00;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (cpu_ack) begin
                seen = 1;
                check("wr_mem_write", mem_write, 1);
                check("wr_mem_read",  mem_read,  0);
                check("wr_mem_addr",  mem_addr,  22'h000123);
                check("wr_mem_din",   mem_din,   16'hBEEF);
                check("wr_mem_wdm",   mem_wdm,   2'b00);
            end
        end
        check("wr_ack_seen", seen, 1);
        cpu_req  = 1'b0;
        man_busy = 1'b1;
        repeat (3) step();
        man_busy = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (cpu_rvalid) cnt++;
        end
        check("wr_no_rvalid", cnt, 0);

        // Saturated requests: 4 video grants then 1 CPU grant.
        mc_auto   = 1'b1;
        video_req = 1'b1;
        cpu_req   = 1'b1;
        new_cpu();
        ngr = 0;
        for (int i = 0; i < 400 && ngr < 10; i++) begin
            step();
            if (video_ack) begin gseq[ngr] = "V"; ngr++; end
            else if (cpu_ack) begin gseq[ngr] = "C"; ngr++; end
            update_reqs(1);
        end
        check("sat_grant_count", ngr, 10);
        for (int i = 0; i < 10; i++) begin
            check("sat_grant_order", (i < ngr) ? gseq[i] : 0, (i % 5 == 4) ? "C" : "V");
        end
        cnt = 0;
        for (int i = 0; i < 3 * RC; i++) begin
            step();
            if (mem_refresh) cnt++;
            update_reqs(1);
        end
        check("sat_refresh_issued", (cnt >= 2) ? 1 : 0, 1);
        check("sat_no_overrun", refresh_overrun, 0);

        // Random traffic.
        traffic(2, 3000);

        // Reset while an operation is in the BUSY phase.
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            step();
            seen = mem_read;
            if (!seen) update_reqs(2);
        end
        check("rst_mid_read_seen", seen, 1);
        video_req = 1'b0;
        cpu_req   = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = mem_busy;
        end
        check("rst_mid_busy_seen", seen, 1);
        step();
        resetn = 1'b0;
        step();
        check("rst_mid_video_rvalid", video_rvalid, 0);
        check("rst_mid_cpu_rvalid",   cpu_rvalid,   0);
        check("rst_mid_mem_addr",     mem_addr,     0);
        check("rst_mid_video_rdata",  video_rdata,  0);
        step();
        resetn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (video_rvalid || cpu_rvalid) cnt++;
        end
        check("rst_mid_no_rvalid", cnt, 0);

        // Controller stuck busy: refresh debt overflows.
        mc_force = 1'b1;
        repeat (4 * RC + 10) step();
        check("stuck_overrun", refresh_overrun, 1);
        mc_force = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mem_refresh) cnt++;
        end
        check("drain_refresh", (cnt >= 3) ? 1 : 0, 1);
        check("overrun_sticky", refresh_overrun, 1);
        traffic(2, 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
